// File: rtl/pcss_link_bridge_if.sv
// Bundle of the host AXI-Stream pair, the PCSS link flit port and the tik line.
// The bridge connects through the slave modport; the environment uses master.
interface pcss_link_bridge_if #(
   parameter int DATA_WIDTH     = 64,
   parameter int CHIPDATA_WIDTH = 16,
   parameter int TIK_CNT_W      = 8
);
   logic [DATA_WIDTH-1:0]     S_AXIS_send_tdata;
   logic                      S_AXIS_send_tvalid;
   logic [DATA_WIDTH/8-1:0]   S_AXIS_send_tkeep;
   logic                      S_AXIS_send_tready;
   logic [DATA_WIDTH-1:0]     M_AXIS_recv_tdata;
   logic                      M_AXIS_recv_tvalid;
   logic                      M_AXIS_recv_tlast;
   logic                      M_AXIS_recv_tready;
   logic [CHIPDATA_WIDTH-1:0] send_data_out;
   logic                      send_data_valid;
   logic                      send_data_par;
   logic                      send_data_ready;
   logic                      send_data_err;
   logic [CHIPDATA_WIDTH-1:0] recv_data_in;
   logic                      recv_data_valid;
   logic                      recv_data_par;
   logic                      recv_data_ready;
   logic                      recv_data_err;
   logic                      tik;
   logic [TIK_CNT_W-1:0]      tik_cnt;

   modport slave (
      input  S_AXIS_send_tdata, S_AXIS_send_tvalid, S_AXIS_send_tkeep,
      output S_AXIS_send_tready,
      output M_AXIS_recv_tdata, M_AXIS_recv_tvalid, M_AXIS_recv_tlast,
      input  M_AXIS_recv_tready,
      output send_data_out, send_data_valid, send_data_par,
      input  send_data_ready, send_data_err,
      input  recv_data_in, recv_data_valid, recv_data_par,
      output recv_data_ready, recv_data_err,
      input  tik,
      output tik_cnt
   );

   modport master (
      output S_AXIS_send_tdata, S_AXIS_send_tvalid, S_AXIS_send_tkeep,
      input  S_AXIS_send_tready,
      input  M_AXIS_recv_tdata, M_AXIS_recv_tvalid, M_AXIS_recv_tlast,
      output M_AXIS_recv_tready,
      input  send_data_out, send_data_valid, send_data_par,
      output send_data_ready, send_data_err,
      output recv_data_in, recv_data_valid, recv_data_par,
      input  recv_data_ready, recv_data_err,
      output tik,
      input  tik_cnt
   );
endinterface

// File: rtl/pcss_link_bridge.sv
// Host AXI-Stream <-> PCSS link bridge: word/flit serdes plus tik edge counter.
// Define PCSS_LINK_PARITY_EN to enable flit parity, CHECK-state retransmit and recv_data_err.
module pcss_link_bridge #(
   parameter int DATA_WIDTH     = 64,
   parameter int CHIPDATA_WIDTH = 16,
   parameter int TIK_CNT_W      = 8
) (
   input logic               clk,
   input logic               rst_n,
   pcss_link_bridge_if.slave bus
);

   localparam int R  = DATA_WIDTH / CHIPDATA_WIDTH;
   localparam int KW = (R > 1) ? $clog2(R) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(R - 1);

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_SEND  = 2'd1,
      TX_CHECK = 2'd2
   } tx_state_e;

   tx_state_e                 tx_state_q, tx_state_d;
   logic [DATA_WIDTH-1:0]     tx_word_q, tx_word_d;
   logic [KW-1:0]             tx_k_q, tx_k_d;
   logic                      tx_adv;
   logic [CHIPDATA_WIDTH-1:0] tx_flit;

   logic [KW-1:0]             rx_cnt_q, rx_cnt_d;
   logic [DATA_WIDTH-1:0]     rx_asm_q, rx_asm_d;
   logic [DATA_WIDTH-1:0]     m_data_q, m_data_d;
   logic                      m_valid_q, m_valid_d;
   logic                      m_last_q, m_last_d;
   logic                      rx_err_q, rx_err_d;
   logic                      rx_ready, rx_accept, rx_bad;
   logic [DATA_WIDTH-1:0]     rx_word;

   logic                      tik_dly_q, tik_dly_d;
   logic [TIK_CNT_W-1:0]      tik_cnt_q, tik_cnt_d;

   // The word register shifts left on every finished flit, so the current flit is always on top.
   assign tx_flit = tx_word_q[DATA_WIDTH-1 -: CHIPDATA_WIDTH];

`ifdef PCSS_LINK_PARITY_EN
   assign tx_adv = (tx_state_q == TX_CHECK) && !bus.send_data_err;
   assign rx_bad = bus.recv_data_par != ^bus.recv_data_in;
`else
   assign tx_adv = (tx_state_q == TX_SEND) && bus.send_data_ready;
   assign rx_bad = 1'b0;
   logic unused_parity_inputs;
   assign unused_parity_inputs = ^{bus.send_data_err, bus.recv_data_par};
`endif

   // NOTE: every _d gets its default before the case, so no path leaves it unassigned (no latch).
   always_comb begin
      tx_state_d = tx_state_q;
      tx_word_d  = tx_word_q;
      tx_k_d     = tx_k_q;
      unique case (tx_state_q)
         TX_IDLE: begin
            if (bus.S_AXIS_send_tvalid && (bus.S_AXIS_send_tkeep != '0)) begin
               tx_word_d  = bus.S_AXIS_send_tdata;
               tx_k_d     = '0;
               tx_state_d = TX_SEND;
            end
         end
         TX_SEND: begin
`ifdef PCSS_LINK_PARITY_EN
            if (bus.send_data_ready) tx_state_d = TX_CHECK;
`endif
         end
         TX_CHECK: tx_state_d = TX_SEND;
         default:  tx_state_d = TX_IDLE;
      endcase
      if (tx_adv) begin
         if (tx_k_q == K_LAST) begin
            tx_state_d = TX_IDLE;
         end else begin
            tx_k_d     = tx_k_q + KW'(1);
            tx_word_d  = tx_word_q << CHIPDATA_WIDTH;
            tx_state_d = TX_SEND;
         end
      end
   end

   // Holding the last flit off while a word is still parked keeps the output register from overrunning.
   assign rx_ready  = !((rx_cnt_q == K_LAST) && m_valid_q);
   assign rx_accept = bus.recv_data_valid && rx_ready;
   assign rx_word   = {rx_asm_q[DATA_WIDTH-CHIPDATA_WIDTH-1:0], bus.recv_data_in};

   always_comb begin
      rx_cnt_d  = rx_cnt_q;
      rx_asm_d  = rx_asm_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      rx_err_d  = rx_accept && rx_bad;
      if (m_valid_q && bus.M_AXIS_recv_tready) m_valid_d = 1'b0;
      if (rx_accept && !rx_bad) begin
         rx_asm_d = rx_word;
         if (rx_cnt_q == K_LAST) begin
            m_data_d  = rx_word;
            m_last_d  = &rx_word;
            m_valid_d = 1'b1;
            rx_cnt_d  = '0;
         end else begin
            rx_cnt_d = rx_cnt_q + KW'(1);
         end
      end
   end

   always_comb begin
      tik_dly_d = bus.tik;
      tik_cnt_d = tik_cnt_q;
      if (tik_dly_q && !bus.tik) tik_cnt_d = tik_cnt_q + TIK_CNT_W'(1);
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_word_q  <= '0;
         tx_k_q     <= '0;
         rx_cnt_q   <= '0;
         rx_asm_q   <= '0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         rx_err_q   <= 1'b0;
         tik_dly_q  <= 1'b0;
         tik_cnt_q  <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_word_q  <= tx_word_d;
         tx_k_q     <= tx_k_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_asm_q   <= rx_asm_d;
         m_data_q   <= m_data_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         rx_err_q   <= rx_err_d;
         tik_dly_q  <= tik_dly_d;
         tik_cnt_q  <= tik_cnt_d;
      end
   end

   // Both readies are gated by rst_n so they read 0 throughout reset, not just after the first edge.
   assign bus.S_AXIS_send_tready = rst_n && (tx_state_q == TX_IDLE);
   assign bus.recv_data_ready    = rst_n && rx_ready;
   assign bus.send_data_valid    = (tx_state_q == TX_SEND);
   assign bus.send_data_out      = bus.send_data_valid ? tx_flit : '0;
`ifdef PCSS_LINK_PARITY_EN
   assign bus.send_data_par      = ^bus.send_data_out;
`else
   assign bus.send_data_par      = 1'b0;
`endif
   assign bus.recv_data_err      = rx_err_q;
   assign bus.M_AXIS_recv_tdata  = m_data_q;
   assign bus.M_AXIS_recv_tvalid = m_valid_q;
   assign bus.M_AXIS_recv_tlast  = m_last_q;
   assign bus.tik_cnt            = tik_cnt_q;

endmodule

// File: tb/tb_pcss_link_bridge.sv
// Scoreboard bench for pcss_link_bridge: queue-based flit/word model, directed cases then random traffic.
// Works with or without PCSS_LINK_PARITY_EN defined.
module tb_pcss_link_bridge;

   localparam int DW = 64;
   localparam int CW = 16;
   localparam int TW = 8;
   localparam int R  = DW / CW;
`ifdef PCSS_LINK_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int TX_CYC = PAR_EN ? 2 * R : R;
   localparam int BOUND  = 5000;

   logic clk;
   logic rst_n;

   pcss_link_bridge_if #(.DATA_WIDTH(DW), .CHIPDATA_WIDTH(CW), .TIK_CNT_W(TW)) bus ();

   pcss_link_bridge #(.DATA_WIDTH(DW), .CHIPDATA_WIDTH(CW), .TIK_CNT_W(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   logic [CW-1:0] tx_q[$];     // flits expected on the link, in order
   logic [CW-1:0] rx_asm[$];   // good flits received towards the next word
   logic [DW-1:0] rx_exp[$];   // words expected on M_AXIS
   bit            tx_pend;     // a flit was accepted; its CHECK cycle is next
   bit            rx_err_exp;
   int            hs_cnt;      // link flit handshakes seen
   int            seen2;       // handshakes of flit 0x0002
   int            rx_words;    // words drained from M_AXIS
   logic [DW-1:0] mon_w;

   int sink_mode;    // 0: ready=1, 1: random ready/err, 2: one err after first 0x0002
   int mready_mode;  // 0: tready=1, 1: random, 2: tready=0

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_s_tready"},  bus.S_AXIS_send_tready, 0);
      check({tag, "_m_tdata"},   bus.M_AXIS_recv_tdata, 0);
      check({tag, "_m_tvalid"},  bus.M_AXIS_recv_tvalid, 0);
      check({tag, "_m_tlast"},   bus.M_AXIS_recv_tlast, 0);
      check({tag, "_send_out"},  bus.send_data_out, 0);
      check({tag, "_send_vld"},  bus.send_data_valid, 0);
      check({tag, "_send_par"},  bus.send_data_par, 0);
      check({tag, "_recv_rdy"},  bus.recv_data_ready, 0);
      check({tag, "_recv_err"},  bus.recv_data_err, 0);
      check({tag, "_tik_cnt"},   bus.tik_cnt, 0);
   endtask

   // Offers one host word; returns #1 after the accepting edge.
   task automatic send_word(input logic [DW-1:0] data, input logic [DW/8-1:0] keep);
      bit ok = 1'b0;
      bus.S_AXIS_send_tdata  = data;
      bus.S_AXIS_send_tkeep  = keep;
      bus.S_AXIS_send_tvalid = 1'b1;
      for (int n = 0; n < BOUND && !ok; n++) begin
         @(negedge clk);
         ok = bus.S_AXIS_send_tready;
      end
      if (ok) begin
         if (keep != '0)
            for (int i = 0; i < R; i++) tx_q.push_back(data[DW-1-i*CW -: CW]);
      end else begin
         check("tx_accept_timeout", bus.S_AXIS_send_tready, 1);
      end
      @(posedge clk);
      #1;
      bus.S_AXIS_send_tvalid = 1'b0;
   endtask

   task automatic rx_flit(input logic [CW-1:0] data, input logic par);
      bit ok = 1'b0;
      bus.recv_data_in    = data;
      bus.recv_data_par   = par;
      bus.recv_data_valid = 1'b1;
      for (int n = 0; n < BOUND && !ok; n++) begin
         @(negedge clk);
         ok = bus.recv_data_ready;
      end
      if (!ok) check("rx_accept_timeout", bus.recv_data_ready, 1);
      @(posedge clk);
      #1;
      bus.recv_data_valid = 1'b0;
   endtask

   // Link sink and M_AXIS consumer, driven just after each rising edge.
   initial begin : sink
      int used2;
      bit fired;
      used2 = 0;
      fired = 1'b0;
      bus.send_data_ready    = 1'b0;
      bus.send_data_err      = 1'b0;
      bus.M_AXIS_recv_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.send_data_err = 1'b0;
         case (sink_mode)
            1: begin
               bus.send_data_ready = ($urandom_range(0, 3) != 0);
               bus.send_data_err   = ($urandom_range(0, 3) == 0);
            end
            2: begin
               bus.send_data_ready = 1'b1;
               if (!fired && seen2 != used2) begin
                  bus.send_data_err = 1'b1;
                  fired = 1'b1;
               end
            end
            default: bus.send_data_ready = 1'b1;
         endcase
         if (sink_mode != 2) begin
            used2 = seen2;
            fired = 1'b0;
         end
         case (mready_mode)
            1:       bus.M_AXIS_recv_tready = ($urandom_range(0, 1) != 0);
            2:       bus.M_AXIS_recv_tready = 1'b0;
            default: bus.M_AXIS_recv_tready = 1'b1;
         endcase
      end
   end

   // Monitor: samples on the falling edge, what it sees is what the next rising edge commits.
   always @(negedge clk) begin
      if (!rst_n) begin
         tx_q.delete();
         rx_asm.delete();
         rx_exp.delete();
         tx_pend    = 1'b0;
         rx_err_exp = 1'b0;
      end else begin
         if (tx_pend) begin
            tx_pend = 1'b0;
            if (!(PAR_EN && bus.send_data_err) && tx_q.size() != 0) void'(tx_q.pop_front());
         end
         if (bus.send_data_valid && bus.send_data_ready) begin
            hs_cnt++;
            if (bus.send_data_out == 16'h0002) seen2++;
            if (tx_q.size() == 0) begin
               check("tx_unexpected_flit", bus.send_data_valid, 0);
            end else begin
               check("tx_flit", bus.send_data_out, tx_q[0]);
               check("tx_par", bus.send_data_par, PAR_EN ? ^tx_q[0] : 1'b0);
               if (PAR_EN) tx_pend = 1'b1;
               else        void'(tx_q.pop_front());
            end
         end

         check("recv_err", bus.recv_data_err, rx_err_exp);
         rx_err_exp = 1'b0;
         check("m_tvalid", bus.M_AXIS_recv_tvalid, rx_exp.size() != 0);
         check("recv_ready", bus.recv_data_ready,
               !(rx_asm.size() == R - 1 && rx_exp.size() != 0));
         if (bus.M_AXIS_recv_tvalid && bus.M_AXIS_recv_tready && rx_exp.size() != 0) begin
            mon_w = rx_exp.pop_front();
            rx_words++;
            check("m_tdata", bus.M_AXIS_recv_tdata, mon_w);
            check("m_tlast", bus.M_AXIS_recv_tlast, mon_w == '1);
         end
         if (bus.recv_data_valid && bus.recv_data_ready) begin
            if (PAR_EN && (bus.recv_data_par != ^bus.recv_data_in)) begin
               rx_err_exp = 1'b1;
            end else begin
               rx_asm.push_back(bus.recv_data_in);
               if (rx_asm.size() == R) begin
                  mon_w = '0;
                  foreach (rx_asm[i]) mon_w = (mon_w << CW) | DW'(rx_asm[i]);
                  rx_exp.push_back(mon_w);
                  rx_asm.delete();
               end
            end
         end
      end
   end

   initial begin : main
      int hs0;
      int w0;
      logic [CW-1:0] f;
      logic [DW/8-1:0] keep;
      sink_mode   = 0;
      mready_mode = 0;
      bus.S_AXIS_send_tdata  = '0;
      bus.S_AXIS_send_tvalid = 1'b0;
      bus.S_AXIS_send_tkeep  = '0;
      bus.recv_data_in       = '0;
      bus.recv_data_valid    = 1'b0;
      bus.recv_data_par      = 1'b0;
      bus.tik                = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #3;
      check_outputs_zero("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("post_reset_s_tready", bus.S_AXIS_send_tready, 1);
      check("post_reset_recv_ready", bus.recv_data_ready, 1);

      // TX word split with latency and cycle count
      idle(1);
      send_word(64'h0001_0002_0003_0004, '1);
      check("tx_first_flit_latency", bus.send_data_valid, 1);
      repeat (TX_CYC - 1) @(posedge clk);
      #1 check("tx_busy_before_end", bus.S_AXIS_send_tready, 0);
      @(posedge clk);
      #1 check("tx_idle_after_word", bus.S_AXIS_send_tready, 1);

      // Retransmit of flit 0x0002
      if (PAR_EN) begin
         sink_mode = 2;
         hs0 = hs_cnt;
         send_word(64'h0001_0002_0003_0004, '1);
         for (int n = 0; n < 200; n++) begin
            if (tx_q.size() == 0 && bus.S_AXIS_send_tready) break;
            idle(1);
         end
         check("tx_retransmit_handshakes", hs_cnt - hs0, 5);
         sink_mode = 0;
         idle(2);
      end

      // tkeep all-zero is dropped
      hs0 = hs_cnt;
      send_word(64'hDEAD_BEEF_0BAD_F00D, '0);
      idle(3 * R);
      check("tkeep_drop_flits", hs_cnt, hs0);
      check("tkeep_drop_ready", bus.S_AXIS_send_tready, 1);

      // RX assembly: end marker word, then a normal word with a bad-parity flit in between
      w0 = rx_words;
      for (int i = 0; i < R; i++) rx_flit(16'hFFFF, ^16'hFFFF);
      rx_flit(16'h1234, ^16'h1234);
      if (PAR_EN) begin
         rx_flit(16'h0001, 1'b0);
         check("rx_bad_par_err_pulse", bus.recv_data_err, 1);
         idle(1);
         check("rx_bad_par_err_clear", bus.recv_data_err, 0);
      end
      rx_flit(16'h5678, ^16'h5678);
      rx_flit(16'h9ABC, ^16'h9ABC);
      rx_flit(16'hDEF0, ^16'hDEF0);
      idle(3);
      check("rx_directed_words", rx_words - w0, 2);

      // RX backpressure: one word parked, then three more flits
      mready_mode = 2;
      idle(1);
      for (int i = 0; i < 2 * R - 1; i++) begin
         f = 16'($urandom);
         rx_flit(f, ^f);
      end
      idle(3);
      check("rx_backpressure_ready_low", bus.recv_data_ready, 0);
      mready_mode = 0;
      idle(3);
      check("rx_backpressure_ready_high", bus.recv_data_ready, 1);
      rx_flit(16'h00A5, ^16'h00A5);
      idle(3);

      // Reset in the middle of a TX word
      hs0 = hs_cnt;
      send_word(64'hAAAA_BBBB_CCCC_DDDD, '1);
      for (int n = 0; n < 100 && hs_cnt - hs0 < 2; n++) idle(1);
      rst_n = 1'b0;
      #1 check_outputs_zero("mid_reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("mid_reset_release_ready", bus.S_AXIS_send_tready, 1);
      idle(3 * R);
      check("mid_reset_no_residual_flits", hs_cnt - hs0, 2);

      // Random traffic on both paths
      sink_mode   = 1;
      mready_mode = 1;
      idle(1);
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               case ($urandom_range(0, 7))
                  0:       keep = '0;
                  1:       keep = 8'($urandom_range(1, 254));
                  default: keep = '1;
               endcase
               send_word({$urandom, $urandom}, keep);
               idle($urandom_range(0, 3));
            end
         end
         begin
            for (int i = 0; i < 240; i++) begin
               f = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
               rx_flit(f, ($urandom_range(0, 7) == 0) ? ~(^f) : ^f);
               idle($urandom_range(0, 2));
            end
         end
      join
      sink_mode   = 0;
      mready_mode = 0;
      for (int n = 0; n < 2000; n++) begin
         if (tx_q.size() == 0 && rx_exp.size() == 0 && bus.S_AXIS_send_tready) break;
         idle(1);
      end
      check("drain_tx_queue", tx_q.size(), 0);
      check("drain_rx_queue", rx_exp.size(), 0);

      // Tik counter: count, wrap, reset mid-pulse
      for (int i = 0; i < 5; i++) begin
         bus.tik = 1'b1; idle(1);
         bus.tik = 1'b0; idle(1);
      end
      check("tik_count_5", bus.tik_cnt, 5);
      for (int i = 0; i < 250; i++) begin
         bus.tik = 1'b1; idle(1);
         bus.tik = 1'b0; idle(1);
      end
      check("tik_count_255", bus.tik_cnt, 255);
      bus.tik = 1'b1; idle(1);
      bus.tik = 1'b0; idle(1);
      check("tik_wrap_256", bus.tik_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         bus.tik = 1'b1; idle(1);
         bus.tik = 1'b0; idle(1);
      end
      check("tik_count_3", bus.tik_cnt, 3);
      bus.tik = 1'b1; idle(1);
      rst_n = 1'b0;
      #1 check("tik_mid_pulse_reset", bus.tik_cnt, 0);
      bus.tik = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      bus.tik = 1'b1; idle(1);
      bus.tik = 1'b0; idle(2);
      check("tik_after_reset", bus.tik_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/pcss_link_bridge.md
# pcss_link_bridge

Parametrised bridge between a host AXI-Stream pair and one PCSS inter-chip link port (16-bit flit, parity, valid/ready/err). It sits between the host DMA and a `pcss_top` edge port. On transmit, it serialises `DATA_WIDTH` words into `DATA_WIDTH/CHIPDATA_WIDTH` flits, MSB first. On receive, it reassembles flits into words, and it counts `tik` periods for host-side timestamping.

## Interface
Clock is `clk`; reset is `rst_n`, asynchronous and active-low. There is one clock domain.

Parameters:
- `DATA_WIDTH`, 64, host word width; must be an integer multiple of `CHIPDATA_WIDTH`, with ratio R = `DATA_WIDTH/CHIPDATA_WIDTH` ≥ 2.
- `CHIPDATA_WIDTH`, 16, link flit width.
- `TIK_CNT_W`, 8, tik counter width.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `S_AXIS_send_tdata`  in  DATA_WIDTH  host word to chip
- `S_AXIS_send_tvalid`  in  1  valid
- `S_AXIS_send_tkeep`  in  DATA_WIDTH/8  byte enables; only all-ones or all-zero are meaningful
- `S_AXIS_send_tready`  out  1  ready
- `M_AXIS_recv_tdata`  out  DATA_WIDTH  word from chip
- `M_AXIS_recv_tvalid`  out  1  valid
- `M_AXIS_recv_tlast`  out  1  high when `tdata` is all ones (end marker)
- `M_AXIS_recv_tready`  in  1  ready
- `send_data_out`  out  CHIPDATA_WIDTH  flit to chip
- `send_data_valid`  out  1  flit valid
- `send_data_par`  out  1  even parity of `send_data_out`
- `send_data_ready`  in  1  chip accepts flit
- `send_data_err`  in  1  chip reports parity error on the last accepted flit
- `recv_data_in`  in  CHIPDATA_WIDTH  flit from chip
- `recv_data_valid`  in  1  flit valid
- `recv_data_par`  in  1  flit parity
- `recv_data_ready`  out  1  bridge accepts flit
- `recv_data_err`  out  1  bridge reports parity error
- `tik`  in  1  chip tik level
- `tik_cnt`  out  TIK_CNT_W  count of tik falling edges

## Operation
**TX state machine: IDLE → SEND → CHECK → SEND …**
- In IDLE, `S_AXIS_send_tready` = 1.
- A handshake with `tkeep` all-zero drops the word and stays in IDLE.
- Any other `tkeep` value latches the word, sets the flit index k = 0 and moves to SEND.
- In SEND, `send_data_valid` = 1 and `send_data_out` = word[DATA_WIDTH-1-k·CHIPDATA_WIDTH -: CHIPDATA_WIDTH]. The output holds until `send_data_ready` = 1, then moves to CHECK.
- In CHECK (one cycle, valid = 0):
  - `send_data_err` = 1 → back to SEND with the same k (resend).
  - Otherwise k+1; if k was R-1, go to IDLE, else go to SEND.

**RX path**
- A flit is accepted when `recv_data_valid` && `recv_data_ready`.
- Parity check: `recv_data_par` ≠ ^`recv_data_in` → the flit is discarded, the flit count is unchanged, and `recv_data_err` = 1 in the next cycle only.
- A good flit shifts into the assembly register (first flit ends up MSB), and the count increments.
- At count R, the word moves to the M_AXIS output register: `tvalid` = 1, `tlast` = (word == all ones), and the count resets to 0.
- `recv_data_ready` = 0 iff count == R-1 and `M_AXIS_recv_tvalid` = 1 (registered-output full). Otherwise it is 1.
- `M_AXIS_recv_tvalid` clears on `tready`.
- `tdata` and `tlast` hold stable while `tvalid` && !`tready`.

**Tik counter**
- `tik` is registered into `tik_dly`.
- When `tik_dly` && !`tik`, `tik_cnt` increments and wraps from 2^TIK_CNT_W−1 to 0.

## Timing
- **Reset values:** all outputs 0 (`S_AXIS_send_tready`, `recv_data_ready` 0 during reset). TX state is IDLE, RX count 0, `tik_cnt` 0.
- **First cycle after reset release:** `S_AXIS_send_tready` = 1 and `recv_data_ready` = 1.
- **Reset mid-operation:** partial TX words and partial RX assemblies are discarded, with no output.
- **TX latency:** first flit valid 1 cycle after the S_AXIS handshake.
- **TX throughput:** with the parity feature, one flit per 2 cycles (SEND + CHECK). With `send_data_ready` tied high, a word takes 2R cycles plus 1 cycle back in IDLE.
- **RX latency:** `M_AXIS_recv_tvalid` rises the cycle after the R-th good flit is accepted.
- **Simultaneous events:** a word completing in the same cycle as an M_AXIS drain is legal. The drain happens first and the new word loads.
- **Err outside CHECK:** `send_data_err` asserted outside CHECK is ignored.

## Configuration
`PCSS_LINK_PARITY_EN`:
- **Defined:** parity is generated and checked, the CHECK state exists, and err-driven retransmit plus `recv_data_err` behave as above.
- **Undefined:**
  - `send_data_par` = 0 and `recv_data_par` is ignored.
  - `recv_data_err` is constant 0 and `send_data_err` is ignored.
  - CHECK is removed. SEND advances k directly on `send_data_ready`, giving one flit per cycle, so a word takes R cycles.

## Test plan
- **TX word split:** R = 4, send 0x0001_0002_0003_0004 with `send_data_ready` = 1 → flits 0x0001, 0x0002, 0x0003, 0x0004 in order; par 1, 1, 0, 1; `S_AXIS_send_tready` back to 1 after the last CHECK.
- **TX retransmit:** assert `send_data_err` in CHECK after flit 0x0002 → 0x0002 is sent again, then 0x0003; exactly 5 flit handshakes in total.
- **RX assembly and end marker:** feed flits 0xFFFF ×4 with correct parity → one M_AXIS word 0xFFFF_FFFF_FFFF_FFFF with `tlast` = 1. Feeding 0x1234, 0x5678, 0x9ABC, 0xDEF0 gives 0x1234_5678_9ABC_DEF0 with `tlast` = 0.
- **RX parity error and backpressure:** a flit 0x0001 with par 0 → `recv_data_err` pulses for 1 cycle, the count is unchanged, and the next good flit fills that slot. With `M_AXIS_recv_tready` = 0 and a word pending, `recv_data_ready` drops at count 3 and rises 1 cycle after drain.
- **tkeep drop and reset:** a word with `tkeep` = 0x00 produces no flits. Asserting `rst_n` low after 2 TX flits → outputs 0; after release, no residual flits.
- **Tik wrap:** 256 tik pulses with `TIK_CNT_W` = 8 → `tik_cnt` returns to 0. A mid-pulse reset clears the count to 0.
